led_round_scheduler: RTL and testbench



---
 rtl/led_game_pkg.sv | 43 ++++
 rtl/led_round_scheduler_if.sv | 31 +++
 rtl/led_round_timer.sv | 26 ++
 rtl/led_round_scheduler.sv | 168 ++++++++++++++++
 tb/tb_led_round_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/led_game_pkg.sv
// rtl/led_game_pkg.sv - shared state type, width helpers and popcount for the LED round scheduler
package led_game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SHOW   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // popcount operates on a fixed-width vector; callers zero-extend their
    // NUM_LEDS-wide masks, so NUM_LEDS must not exceed MAX_LEDS.
    localparam int MAX_LEDS = 64;
    localparam int POP_W    = 7;

    // Timer holds at most (longest phase - 1) because it is loaded with N-1.
    function automatic int timer_width(input int settle, input int show, input int gap);
        int m;
        m = settle;
        if (show > m) m = show;
        if (gap > m) m = gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic int round_width(input int rounds);
        return $clog2(rounds + 1);
    endfunction

    function automatic int score_width(input int leds, input int rounds);
        return $clog2(leds * rounds + 1);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_LEDS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/led_round_scheduler_if.sv
// rtl/led_round_scheduler_if.sv - player/LED-bank/display bundle for the LED round scheduler
// master: drives start, led_in, hit; observes enable_out, target_mask,
//         round_active, round_count, score, done.
// slave:  the scheduler side of the same signals.
interface led_round_scheduler_if #(
    parameter int NUM_LEDS   = 8,
    parameter int NUM_ROUNDS = 10
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam int SW = $clog2(NUM_LEDS * NUM_ROUNDS + 1);

    logic                start;
    logic [NUM_LEDS-1:0] led_in;
    logic [NUM_LEDS-1:0] hit;
    logic [NUM_LEDS-1:0] enable_out;
    logic [NUM_LEDS-1:0] target_mask;
    logic                round_active;
    logic [RW-1:0]       round_count;
    logic [SW-1:0]       score;
    logic                done;

    modport master (
        output start, led_in, hit,
        input  enable_out, target_mask, round_active, round_count, score, done
    );

    modport slave (
        input  start, led_in, hit,
        output enable_out, target_mask, round_active, round_count, score, done
    );
endinterface

// File: rtl/led_round_timer.sv
// rtl/led_round_timer.sv - loadable down-counter shared by the SETTLE, SHOW and GAP phases
// Ports: clk, reset (sync active-high), load, load_value, expired.
// Loading N-1 makes expired rise on the Nth cycle after the load edge.
module led_round_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/led_round_scheduler.sv
// rtl/led_round_scheduler.sv - round sequencer for a bank of LED randomisers
// Ports: clk, reset (sync active-high), bus (slave modport: start, led_in, hit
//        in; enable_out, target_mask, round_active, round_count, score, done out).
// Optional macro MISS_PENALTY_EN: misses in SHOW subtract from score, floored at 0.
module led_round_scheduler
    import led_game_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int SHOW_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 200,
    parameter int NUM_ROUNDS    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    led_round_scheduler_if.slave  bus
);
    localparam int TW = timer_width(SETTLE_CYCLES, SHOW_CYCLES, GAP_CYCLES);
    localparam int RW = round_width(NUM_ROUNDS);
    localparam int SW = score_width(NUM_LEDS, NUM_ROUNDS);
    localparam int PW = $clog2(NUM_LEDS + 1);

    state_t              state_q, state_d;
    logic [NUM_LEDS-1:0] enable_q, enable_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [SW-1:0]       score_q, score_d;
    logic [RW-1:0]       round_q, round_d;
    logic                done_q, done_d;
    logic                active_q, active_d;

    logic                timer_load;
    logic [TW-1:0]       timer_value;
    logic                timer_expired;

    logic [NUM_LEDS-1:0] valid;
    logic [NUM_LEDS-1:0] mask_next;
    logic [PW-1:0]       hits;
    logic [SW:0]         score_sum;
    logic [SW-1:0]       score_next;

    led_round_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    // Hit scoring, evaluated every cycle but only committed in SHOW.
    always_comb begin
        valid     = bus.hit & mask_q;
        mask_next = mask_q & ~valid;
        hits      = PW'(popcount(MAX_LEDS'(valid)));
        score_sum = (SW+1)'(score_q) + (SW+1)'(hits);
`ifdef MISS_PENALTY_EN
        begin
            logic [PW-1:0] misses;
            misses = PW'(popcount(MAX_LEDS'(bus.hit & ~mask_q)));
            // Hits and misses of one cycle are netted before the floor.
            if (score_sum >= (SW+1)'(misses)) begin
                score_next = SW'(score_sum - (SW+1)'(misses));
            end else begin
                score_next = '0;
            end
        end
`else
        score_next = SW'(score_sum);
`endif
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        mask_d      = mask_q;
        score_d     = score_q;
        round_d     = round_q;
        done_d      = done_q;
        active_d    = active_q;
        timer_load  = 1'b0;
        timer_value = '0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = SETTLE;
                    score_d     = '0;
                    round_d     = '0;
                    done_d      = 1'b0;
                    enable_d    = '1;
                    active_d    = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = TW'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_d     = SHOW;
                    mask_d      = bus.led_in;
                    enable_d    = bus.led_in;
                    timer_load  = 1'b1;
                    timer_value = TW'(SHOW_CYCLES - 1);
                end
            end
            SHOW: begin
                score_d = score_next;
                // Early exit as soon as every lit target has been hit; an
                // empty capture therefore leaves after one SHOW cycle.
                if (mask_next == '0 || timer_expired) begin
                    state_d     = GAP;
                    round_d     = round_q + 1'b1;
                    mask_d      = '0;
                    enable_d    = '0;
                    active_d    = 1'b0;
                    timer_load  = 1'b1;
                    timer_value = TW'(GAP_CYCLES - 1);
                end else begin
                    mask_d   = mask_next;
                    enable_d = mask_next;
                end
            end
            GAP: begin
                if (timer_expired) begin
                    if (round_q == RW'(NUM_ROUNDS)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = SETTLE;
                        enable_d    = '1;
                        active_d    = 1'b1;
                        timer_load  = 1'b1;
                        timer_value = TW'(SETTLE_CYCLES - 1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= '0;
            mask_q   <= '0;
            score_q  <= '0;
            round_q  <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            mask_q   <= mask_d;
            score_q  <= score_d;
            round_q  <= round_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign bus.enable_out   = enable_q;
    assign bus.target_mask  = mask_q;
    assign bus.score        = score_q;
    assign bus.round_count  = round_q;
    assign bus.done         = done_q;
    assign bus.round_active = active_q;
endmodule

// File: tb/tb_led_round_scheduler.sv
// tb/tb_led_round_scheduler.sv - self-checking bench for led_round_scheduler
module tb_led_round_scheduler;
    localparam int NL = 4;
    localparam int ST = 2;
    localparam int SH = 10;
    localparam int GP = 3;
    localparam int NR = 2;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_SHOW = 2, P_GAP = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    led_round_scheduler_if #(.NUM_LEDS(NL), .NUM_ROUNDS(NR)) bus ();

    led_round_scheduler #(
        .NUM_LEDS(NL), .SETTLE_CYCLES(ST), .SHOW_CYCLES(SH),
        .GAP_CYCLES(GP), .NUM_ROUNDS(NR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus cycles spent in it.
    int        m_phase = P_IDLE;
    int        m_elapsed = 0;
    logic [3:0] m_targets = '0;
    int        m_score = 0;
    int        m_rounds = 0;
    bit        m_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] v, miss;
        if (reset) begin
            m_phase = P_IDLE; m_elapsed = 0; m_targets = '0;
            m_score = 0; m_rounds = 0; m_valid = 1;
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: if (bus.start) begin
                m_score = 0; m_rounds = 0; m_phase = P_SETTLE; m_elapsed = 0;
            end
            P_SETTLE: begin
                m_elapsed++;
                if (m_elapsed == ST) begin
                    m_targets = bus.led_in; m_phase = P_SHOW; m_elapsed = 0;
                end
            end
            P_SHOW: begin
                v    = bus.hit & m_targets;
                miss = bus.hit & ~m_targets;
                m_score += $countones(v);
`ifdef MISS_PENALTY_EN
                m_score -= $countones(miss);
                if (m_score < 0) m_score = 0;
`endif
                m_targets &= ~v;
                m_elapsed++;
                if (m_targets == 0 || m_elapsed == SH) begin
                    m_rounds++; m_targets = '0; m_phase = P_GAP; m_elapsed = 0;
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == GP) begin
                    m_phase = (m_rounds == NR) ? P_DONE : P_SETTLE;
                    m_elapsed = 0;
                end
            end
        endcase
    endtask

    // Single compare process: model advances on the edge, outputs checked 2ns later.
    always @(posedge clk) begin
        int exp_en;
        model_step();
        #2;
        if (m_valid) begin
            exp_en = (m_phase == P_SETTLE) ? 4'hF : (m_phase == P_SHOW) ? int'(m_targets) : 0;
            chk("m_enable_out",   int'(bus.enable_out),   exp_en);
            chk("m_target_mask",  int'(bus.target_mask),  int'(m_targets));
            chk("m_round_active", int'(bus.round_active),
                int'(m_phase == P_SETTLE || m_phase == P_SHOW));
            chk("m_round_count",  int'(bus.round_count),  m_rounds);
            chk("m_score",        int'(bus.score),        m_score);
            chk("m_done",         int'(bus.done),         int'(m_phase == P_DONE));
        end
    end

    task automatic tick(input logic r, input logic s, input logic [3:0] led, input logic [3:0] h);
        @(negedge clk);
        reset = r; bus.start = s; bus.led_in = led; bus.hit = h;
        @(posedge clk);
        #3;
    endtask

    // Entered right after a no-hit capture edge; returns SHOW and GAP lengths.
    task automatic measure(output int show_n, output int gap_n);
        show_n = 1;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 4'h0, 4'h0);
            if (bus.target_mask != 0) show_n++;
            else break;
        end
        gap_n = 1;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 4'h0, 4'h0);
            if (bus.enable_out == 0 && !bus.done) gap_n++;
            else break;
        end
    endtask

    initial begin
        int sn, gn;
        reset = 1'b1; bus.start = 1'b0; bus.led_in = '0; bus.hit = '0;

        tick(1, 0, 4'h0, 4'h0);
        chk("rst_enable", int'(bus.enable_out), 0);
        chk("rst_mask",   int'(bus.target_mask), 0);
        chk("rst_score",  int'(bus.score), 0);
        chk("rst_rounds", int'(bus.round_count), 0);
        chk("rst_done",   int'(bus.done), 0);
        chk("rst_active", int'(bus.round_active), 0);

        tick(0, 1, 4'h0, 4'h0);
        chk("start_enable", int'(bus.enable_out), 'hF);
        tick(0, 0, 4'h5, 4'h0);
        tick(0, 0, 4'h5, 4'h0);
        chk("capture_mask",   int'(bus.target_mask), 'h5);
        chk("capture_enable", int'(bus.enable_out), 'h5);
        tick(0, 0, 4'h0, 4'h1);
        chk("hit1_score", int'(bus.score), 1);
        chk("hit1_mask",  int'(bus.target_mask), 'h4);
        tick(0, 0, 4'h0, 4'h4);
        chk("early_score",  int'(bus.score), 2);
        chk("early_rounds", int'(bus.round_count), 1);
        chk("early_enable", int'(bus.enable_out), 0);
        tick(0, 0, 4'h0, 4'h0);
        tick(0, 0, 4'h0, 4'h0);
        chk("gap_enable", int'(bus.enable_out), 0);
        tick(0, 0, 4'h0, 4'h0);
        chk("gap_to_settle", int'(bus.enable_out), 'hF);

        tick(0, 0, 4'h3, 4'h0);
        tick(0, 0, 4'h3, 4'h0);
        measure(sn, gn);
        chk("r2_show_len", sn, 10);
        chk("r2_gap_len",  gn, 3);
        chk("done_flag",   int'(bus.done), 1);
        chk("done_rounds", int'(bus.round_count), 2);
        chk("done_score",  int'(bus.score), 2);

        tick(0, 1, 4'h0, 4'h0);
        chk("restart_score",  int'(bus.score), 0);
        chk("restart_rounds", int'(bus.round_count), 0);
        chk("restart_enable", int'(bus.enable_out), 'hF);
        tick(0, 0, 4'h5, 4'h0);
        tick(0, 0, 4'h5, 4'h0);
        tick(0, 0, 4'h0, 4'h1);
        chk("pre_reset_score", int'(bus.score), 1);
        tick(1, 0, 4'h0, 4'h4);
        chk("midrst_score",  int'(bus.score), 0);
        chk("midrst_mask",   int'(bus.target_mask), 0);
        chk("midrst_enable", int'(bus.enable_out), 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 4'h0, 4'hF);
        chk("idle_hits_ignored", int'(bus.score), 0);

        tick(0, 1, 4'h0, 4'h0);
        tick(0, 0, 4'h3, 4'h0);
        tick(0, 0, 4'h3, 4'h0);
        measure(sn, gn);
        chk("g3_show_len", sn, 10);
        chk("g3_gap_len",  gn, 3);
        chk("g3_settle",   int'(bus.enable_out), 'hF);
        tick(0, 0, 4'h3, 4'h0);
        tick(0, 0, 4'h3, 4'h0);
        tick(0, 0, 4'h0, 4'h2);
        chk("pen_pre_score", int'(bus.score), 1);
        chk("pen_pre_mask",  int'(bus.target_mask), 'h1);
        tick(0, 0, 4'h0, 4'h6);
`ifdef MISS_PENALTY_EN
        chk("miss_penalty", int'(bus.score), 0);
`else
        chk("miss_ignored", int'(bus.score), 1);
`endif
        chk("miss_mask", int'(bus.target_mask), 'h1);
        tick(0, 0, 4'h0, 4'h1);
        chk("final_round", int'(bus.round_count), 2);

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
                 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
